// File: rtl/ifu_ifetch.sv
// IFU fetch controller: owns the fetch PC, keeps one fetch in flight and holds the returned word in the IR
// for the BPU and EXU. Pipeline flush redirects override everything else.
module ifu_ifetch #(
  parameter int unsigned        PC_SIZE  = 32,
  parameter logic [PC_SIZE-1:0] RESET_PC = PC_SIZE'(32'h8000_0000)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ifu_req_valid,
  input  logic               ifu_req_ready,
  output logic [PC_SIZE-1:0] ifu_req_pc,
  input  logic               ifu_rsp_valid,
  output logic               ifu_rsp_ready,
  input  logic [31:0]        ifu_rsp_instr,
  input  logic               ifu_rsp_err,
  output logic               ir_valid,
  output logic [31:0]        ir_instr,
  output logic [PC_SIZE-1:0] ir_pc,
  output logic               ir_buserr,
  output logic               ir_valid_clr,
  output logic               ifu_o_valid,
  input  logic               ifu_o_ready,
  input  logic               bpu_wait,
  input  logic               prdt_taken,
  input  logic [PC_SIZE-1:0] prdt_pc_add_op1,
  input  logic [PC_SIZE-1:0] prdt_pc_add_op2,
  input  logic               pipe_flush_req,
  input  logic [PC_SIZE-1:0] pipe_flush_pc
);

  localparam int unsigned INSTR_W = 32;

  typedef enum logic [2:0] {
    ST_RST  = 3'd0,
    ST_REQ  = 3'd1,
    ST_RSP  = 3'd2,
    ST_NXT  = 3'd3,
    ST_DROP = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [PC_SIZE-1:0] pc_q, pc_d;
  logic [PC_SIZE-1:0] flush_pc_q, flush_pc_d;
  logic               pend_q, pend_d;
  logic               sent_q;
  logic               req_hs, rsp_hs;
  logic               ir_load, sent_set;
  logic [PC_SIZE-1:0] pred_pc, flush_tgt;

  // Handshakes and IR handoff are pure decodes of registered state and inputs.
  assign ifu_req_pc    = pc_q;
  assign ifu_req_valid = (state_q == ST_REQ);
  assign ifu_o_valid   = ir_valid & (sent_q | ~bpu_wait);
  assign ir_valid_clr  = ifu_o_valid & ifu_o_ready;
  assign ifu_rsp_ready = (state_q == ST_DROP) |
                         ((state_q == ST_RSP) & (~ir_valid | ir_valid_clr));
  assign req_hs        = ifu_req_valid & ifu_req_ready;
  assign rsp_hs        = ifu_rsp_valid & ifu_rsp_ready;

  // A bus-error word never redirects: fall through to the sequential PC.
  assign pred_pc   = (prdt_taken & ~ir_buserr)
                   ? ((prdt_pc_add_op1 + prdt_pc_add_op2) & ~PC_SIZE'(1))
                   : (ir_pc + PC_SIZE'(4));
  assign flush_tgt = pipe_flush_pc & ~PC_SIZE'(1);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flush_pc_d = flush_pc_q;
    pend_d     = pend_q;
    ir_load    = 1'b0;
    sent_set   = 1'b0;

    case (state_q)
      ST_RST: state_d = ST_REQ;
      ST_REQ: begin
        if (req_hs) begin
          state_d = pend_q ? ST_DROP : ST_RSP;
          pend_d  = 1'b0;
        end
      end
      ST_RSP: begin
        if (rsp_hs) begin
          ir_load = 1'b1;
          state_d = ST_NXT;
        end
      end
      ST_NXT: begin
        if (ir_valid && !bpu_wait) begin
          pc_d     = pred_pc;
          sent_set = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_DROP: begin
        if (rsp_hs) begin
          pc_d    = flush_pc_q;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_RST;
    endcase

    // Flush overrides; a request already on the bus keeps its PC until accepted.
    if (pipe_flush_req) begin
      ir_load    = 1'b0;
      sent_set   = 1'b0;
      flush_pc_d = flush_tgt;
      case (state_q)
        ST_REQ: begin
          pc_d = pc_q;
          if (req_hs) begin
            state_d = ST_DROP;
            pend_d  = 1'b0;
          end else begin
            state_d = ST_REQ;
            pend_d  = 1'b1;
          end
        end
        ST_RSP, ST_DROP: begin
          if (rsp_hs) begin
            pc_d    = flush_tgt;
            state_d = ST_REQ;
          end else begin
            pc_d    = pc_q;
            state_d = ST_DROP;
          end
        end
        default: begin
          pc_d    = flush_tgt;
          state_d = ST_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RST;
      pc_q       <= RESET_PC;
      flush_pc_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flush_pc_q <= flush_pc_d;
      pend_q     <= pend_d;
    end
  end

  // IR: a load in the same cycle as a consume is a fresh instruction, so it stays valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_valid  <= 1'b0;
      ir_instr  <= '0;
      ir_pc     <= '0;
      ir_buserr <= 1'b0;
      sent_q    <= 1'b0;
    end else if (pipe_flush_req) begin
      ir_valid <= 1'b0;
      sent_q   <= 1'b0;
    end else if (ir_load) begin
      ir_valid  <= 1'b1;
      ir_instr  <= INSTR_W'(ifu_rsp_instr);
      ir_pc     <= pc_q;
      ir_buserr <= ifu_rsp_err;
      sent_q    <= 1'b0;
    end else if (ir_valid_clr) begin
      ir_valid <= 1'b0;
      sent_q   <= 1'b0;
    end else if (sent_set) begin
      sent_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ifu_ifetch.sv
// Bench for ifu_ifetch: directed walkthrough of fetch, prediction, stall, flush and reset, then a randomized
// run checked against a transaction-level model of request PCs and IR contents.
`timescale 1ns/1ps
module tb_ifu_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_pc;
  logic        ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_rsp_instr;
  logic        ifu_rsp_err;
  logic        ir_valid;
  logic [31:0] ir_instr, ir_pc;
  logic        ir_buserr, ir_valid_clr, ifu_o_valid, ifu_o_ready;
  logic        bpu_wait, prdt_taken;
  logic [31:0] prdt_pc_add_op1, prdt_pc_add_op2;
  logic        pipe_flush_req;
  logic [31:0] pipe_flush_pc;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  // model state for the randomized run
  logic [31:0] exp_pc, stale_pc, mem_pc, mem_instr, c_instr, c_pc, r_op1, r_op2, got_pc;
  logic        mem_err, c_err, r_taken;
  logic        mem_busy, mem_discard, stale_next, ir_chk, c_discard, flush_prev;
  logic        req_hs, rsp_hs, fl;
  int unsigned mem_delay, n_loaded;

  always #5 clk = ~clk;

  ifu_ifetch dut (
    .clk             (clk),
    .rst             (rst),
    .ifu_req_valid   (ifu_req_valid),
    .ifu_req_ready   (ifu_req_ready),
    .ifu_req_pc      (ifu_req_pc),
    .ifu_rsp_valid   (ifu_rsp_valid),
    .ifu_rsp_ready   (ifu_rsp_ready),
    .ifu_rsp_instr   (ifu_rsp_instr),
    .ifu_rsp_err     (ifu_rsp_err),
    .ir_valid        (ir_valid),
    .ir_instr        (ir_instr),
    .ir_pc           (ir_pc),
    .ir_buserr       (ir_buserr),
    .ir_valid_clr    (ir_valid_clr),
    .ifu_o_valid     (ifu_o_valid),
    .ifu_o_ready     (ifu_o_ready),
    .bpu_wait        (bpu_wait),
    .prdt_taken      (prdt_taken),
    .prdt_pc_add_op1 (prdt_pc_add_op1),
    .prdt_pc_add_op2 (prdt_pc_add_op2),
    .pipe_flush_req  (pipe_flush_req),
    .pipe_flush_pc   (pipe_flush_pc)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
  endtask

  // Called just after a negedge; returns just after the negedge following the response handshake.
  task automatic fetch(input logic [31:0] instr, input logic err, output logic [31:0] pc);
    int n;
    n = 0;
    ifu_req_ready = 1'b1;
    while (!ifu_req_valid && n < 20) begin @(negedge clk); #1; n++; end
    chk1("fetch_req_seen", ifu_req_valid, 1'b1);
    pc = ifu_req_pc;
    @(negedge clk);
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_instr = instr;
    ifu_rsp_err   = err;
    #1;
    n = 0;
    while (!ifu_rsp_ready && n < 20) begin @(negedge clk); #1; n++; end
    chk1("fetch_rsp_seen", ifu_rsp_ready, 1'b1);
    @(negedge clk);
    ifu_rsp_valid = 1'b0;
    ifu_rsp_err   = 1'b0;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_instr = '0; ifu_rsp_err = 1'b0;
    ifu_o_ready = 1'b1; bpu_wait = 1'b0; prdt_taken = 1'b0;
    prdt_pc_add_op1 = '0; prdt_pc_add_op2 = '0; pipe_flush_req = 1'b0; pipe_flush_pc = '0;
    repeat (3) @(negedge clk);
    #1;
    chk1 ("rst_req_valid", ifu_req_valid, 1'b0);
    chk1 ("rst_rsp_ready", ifu_rsp_ready, 1'b0);
    chk1 ("rst_ir_valid",  ir_valid, 1'b0);
    chk32("rst_ir_instr",  ir_instr, 32'h0);
    chk32("rst_ir_pc",     ir_pc, 32'h0);
    chk1 ("rst_ir_buserr", ir_buserr, 1'b0);
    chk1 ("rst_o_valid",   ifu_o_valid, 1'b0);

    // reset release: RST -> REQ at the first edge
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    chk1 ("first_req_valid", ifu_req_valid, 1'b1);
    chk32("first_req_pc", ifu_req_pc, 32'h8000_0000);

    fetch(32'h0000_0013, 1'b0, got_pc);
    chk32("t1_req_pc", got_pc, 32'h8000_0000);
    chk1 ("t1_ir_valid", ir_valid, 1'b1);
    chk32("t1_ir_instr", ir_instr, 32'h0000_0013);
    chk32("t1_ir_pc", ir_pc, 32'h8000_0000);
    chk1 ("t1_no_req_yet", ifu_req_valid, 1'b0);
    chk1 ("t1_o_valid", ifu_o_valid, 1'b1);
    chk1 ("t1_clr", ir_valid_clr, 1'b1);
    @(negedge clk); #1;
    chk1 ("t1_next_req", ifu_req_valid, 1'b1);
    chk32("t2_seq_pc1", ifu_req_pc, 32'h8000_0004);
    chk1 ("t1_ir_consumed", ir_valid, 1'b0);

    fetch(32'h0000_0093, 1'b0, got_pc);
    @(negedge clk); #1;
    chk32("t2_seq_pc2", ifu_req_pc, 32'h8000_0008);

    // JAL then JALR (odd sum, bit0 dropped), then a bus error that must ignore the prediction
    prdt_taken = 1'b1; prdt_pc_add_op1 = 32'h8000_0010; prdt_pc_add_op2 = 32'h0000_0020;
    fetch(32'h0200_006F, 1'b0, got_pc);
    @(negedge clk); #1;
    chk32("t3_jal_pc", ifu_req_pc, 32'h8000_0030);
    prdt_pc_add_op1 = 32'h8000_0100; prdt_pc_add_op2 = 32'h0000_0001;
    fetch(32'h0000_8067, 1'b0, got_pc);
    chk32("t3_jal_target_fetched", got_pc, 32'h8000_0030);
    @(negedge clk); #1;
    chk32("t3_jalr_pc", ifu_req_pc, 32'h8000_0100);
    fetch(32'h0000_8067, 1'b1, got_pc);
    chk1 ("t3_buserr", ir_buserr, 1'b1);
    @(negedge clk); #1;
    chk32("t3_err_seq_pc", ifu_req_pc, 32'h8000_0104);
    prdt_taken = 1'b0;

    // bpu_wait holds off both the next request and the EXU offer
    bpu_wait = 1'b1;
    fetch(32'h0000_0113, 1'b0, got_pc);
    chk32("t4_pc", got_pc, 32'h8000_0104);
    chk1 ("t4_c1_o_valid", ifu_o_valid, 1'b0);
    chk1 ("t4_c1_req", ifu_req_valid, 1'b0);
    @(negedge clk); #1;
    chk1 ("t4_c2_o_valid", ifu_o_valid, 1'b0);
    chk1 ("t4_c2_req", ifu_req_valid, 1'b0);
    @(negedge clk); bpu_wait = 1'b0; #1;
    chk1 ("t4_c3_o_valid", ifu_o_valid, 1'b1);
    @(negedge clk); #1;
    chk1 ("t4_req", ifu_req_valid, 1'b1);
    chk32("t4_req_pc", ifu_req_pc, 32'h8000_0108);

    // EXU stalls: next response must wait until the IR is consumed
    ifu_o_ready = 1'b0;
    fetch(32'hAAAA_0001, 1'b0, got_pc);
    ifu_req_ready = 1'b1;
    @(negedge clk); #1;
    chk1 ("t5_req", ifu_req_valid, 1'b1);
    chk32("t5_req_pc", ifu_req_pc, 32'h8000_010C);
    @(negedge clk);
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b1; ifu_rsp_instr = 32'hBBBB_0002;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      chk1 ("t5_rsp_blocked", ifu_rsp_ready, 1'b0);
      chk32("t5_ir_stable", ir_instr, 32'hAAAA_0001);
      chk1 ("t5_o_valid", ifu_o_valid, 1'b1);
    end
    @(negedge clk); ifu_o_ready = 1'b1; #1;
    chk1 ("t5_clr", ir_valid_clr, 1'b1);
    chk1 ("t5_rsp_ready", ifu_rsp_ready, 1'b1);
    @(negedge clk); ifu_rsp_valid = 1'b0; ifu_o_ready = 1'b0; #1;
    chk1 ("t5_reload_valid", ir_valid, 1'b1);
    chk32("t5_reload_instr", ir_instr, 32'hBBBB_0002);
    chk32("t5_reload_pc", ir_pc, 32'h8000_010C);

    // flush while waiting for a response
    ifu_req_ready = 1'b1;
    @(negedge clk); #1;
    chk32("t6_req_pc", ifu_req_pc, 32'h8000_0110);
    @(negedge clk);
    ifu_req_ready = 1'b0; pipe_flush_req = 1'b1; pipe_flush_pc = 32'h8000_2001;
    #1;
    chk1 ("t6_rsp_not_ready", ifu_rsp_ready, 1'b0);
    @(negedge clk);
    pipe_flush_req = 1'b0; ifu_rsp_valid = 1'b1; ifu_rsp_instr = 32'hDEAD_BEEF;
    #1;
    chk1 ("t6_ir_invalid", ir_valid, 1'b0);
    chk1 ("t6_drop_ready", ifu_rsp_ready, 1'b1);
    @(negedge clk); ifu_rsp_valid = 1'b0; #1;
    chk32("t6_ir_untouched", ir_instr, 32'hBBBB_0002);
    chk1 ("t6_ir_still_invalid", ir_valid, 1'b0);
    chk1 ("t6_req", ifu_req_valid, 1'b1);
    chk32("t6_flush_pc", ifu_req_pc, 32'h8000_2000);

    // reset in the middle of RSP
    ifu_req_ready = 1'b1;
    @(negedge clk); ifu_req_ready = 1'b0; #1;
    chk1 ("t6_in_rsp", ifu_rsp_ready, 1'b1);
    rst = 1'b0; #1;
    chk1 ("t6_rst_req_valid", ifu_req_valid, 1'b0);
    chk1 ("t6_rst_rsp_ready", ifu_rsp_ready, 1'b0);
    chk1 ("t6_rst_ir_valid", ir_valid, 1'b0);
    chk32("t6_rst_ir_instr", ir_instr, 32'h0);
    chk32("t6_rst_ir_pc", ir_pc, 32'h0);
    @(negedge clk); rst = 1'b1; ifu_o_ready = 1'b1;
    @(negedge clk); #1;
    chk1 ("t6_refetch", ifu_req_valid, 1'b1);
    chk32("t6_refetch_pc", ifu_req_pc, 32'h8000_0000);

    // randomized run against the transaction-level model
    exp_pc = 32'h8000_0000; stale_pc = '0; mem_pc = '0; mem_instr = '0; mem_err = 1'b0;
    c_instr = '0; c_pc = '0; c_err = 1'b0; r_taken = 1'b0; r_op1 = '0; r_op2 = '0;
    mem_busy = 1'b0; mem_discard = 1'b0; stale_next = 1'b0; ir_chk = 1'b0; c_discard = 1'b0;
    flush_prev = 1'b0; mem_delay = 0; n_loaded = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (ir_chk) begin
        if (c_discard) begin
          chk1("rnd_discarded", ir_valid, 1'b0);
        end else begin
          chk1 ("rnd_ir_valid", ir_valid, 1'b1);
          chk32("rnd_ir_instr", ir_instr, c_instr);
          chk32("rnd_ir_pc", ir_pc, c_pc);
          chk1 ("rnd_ir_buserr", ir_buserr, c_err);
          r_taken = 1'($urandom_range(0, 1));
          r_op1   = $urandom;
          r_op2   = $urandom;
          exp_pc  = (r_taken && !c_err) ? ((r_op1 + r_op2) & ~32'h1) : (c_pc + 32'd4);
          n_loaded++;
        end
        ir_chk = 1'b0;
      end
      if (flush_prev) chk1("rnd_flush_clears_ir", ir_valid, 1'b0);
      flush_prev = 1'b0;

      prdt_taken      = r_taken;
      prdt_pc_add_op1 = r_op1;
      prdt_pc_add_op2 = r_op2;
      ifu_req_ready   = ($urandom_range(0, 3) != 0);
      ifu_o_ready     = ($urandom_range(0, 2) != 0);
      bpu_wait        = ($urandom_range(0, 3) == 0);
      fl              = ($urandom_range(0, 29) == 0);
      pipe_flush_req  = fl;
      if (fl) pipe_flush_pc = $urandom;
      ifu_rsp_valid   = mem_busy && (mem_delay == 0);
      ifu_rsp_instr   = mem_instr;
      ifu_rsp_err     = mem_err;
      #1;
      req_hs = ifu_req_valid && ifu_req_ready;
      rsp_hs = ifu_rsp_valid && ifu_rsp_ready;

      if (rsp_hs) begin
        ir_chk = 1'b1; c_discard = mem_discard;
        c_instr = mem_instr; c_pc = mem_pc; c_err = mem_err;
        mem_busy = 1'b0;
      end else if (mem_busy && mem_delay > 0) begin
        mem_delay--;
      end
      if (req_hs) begin
        chk1("rnd_one_outstanding", mem_busy, 1'b0);
        if (stale_next) begin
          chk32("rnd_stale_req_pc", ifu_req_pc, stale_pc);
          mem_pc = stale_pc; mem_discard = 1'b1; stale_next = 1'b0;
        end else begin
          chk32("rnd_req_pc", ifu_req_pc, exp_pc);
          mem_pc = exp_pc; mem_discard = 1'b0;
        end
        mem_busy  = 1'b1;
        mem_delay = $urandom_range(0, 3);
        mem_instr = $urandom;
        mem_err   = ($urandom_range(0, 7) == 0);
      end
      // a flush kills every fetch already accepted or already on the bus
      if (fl) begin
        if (mem_busy) mem_discard = 1'b1;
        if (rsp_hs) c_discard = 1'b1;
        if (!req_hs && ifu_req_valid && !stale_next) begin
          stale_next = 1'b1;
          stale_pc   = exp_pc;
        end
        exp_pc     = pipe_flush_pc & ~32'h1;
        flush_prev = 1'b1;
      end
    end
    pipe_flush_req = 1'b0;
    chk1("rnd_progress", (n_loaded >= 100), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
